// File: rtl/i2c_burst_master.sv
// I2C single-master burst engine: START, 7-bit address, N data bytes
// (write via ready/valid, read via strobe), STOP. SCL is built from four
// divider ticks per bit.
module i2c_burst_master #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       slave_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [7:0]       data_out,
  output logic             data_out_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic [3:0]       state,
  output logic             sclk,
  output logic             sda_out,
  input  logic             sda_in
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    ADDR      = 4'd2,
    ADDR_ACK  = 4'd3,
    WR        = 4'd4,
    WR_ACK    = 4'd5,
    RD        = 4'd6,
    RD_ACK    = 4'd7,
    STOP      = 4'd8,
    WAIT_DATA = 4'd9
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       qtr;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             rw_q;
  logic [LEN_W-1:0] remain;
  logic             have_data;

  assign tick  = busy && (div_cnt == CNT_W'(CLK_DIV - 1));
  assign state = st;

  // Quarter-bit divider, held at zero while idle so every transfer starts aligned
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!busy || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Protocol FSM; Q0 drive SDA, Q1 raise SCL, Q2 sample SDA, Q3 drop SCL
  always_ff @(posedge clk) begin
    if (!rst) begin
      st             <= IDLE;
      qtr            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      rw_q           <= 1'b0;
      remain         <= '0;
      have_data      <= 1'b0;
      sclk           <= 1'b1;
      sda_out        <= 1'b1;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_in_ready  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      nack           <= 1'b0;
    end else begin
      done           <= 1'b0;
      data_out_valid <= 1'b0;
      // busy covers the done cycle, then drops
      if (done) busy <= 1'b0;

      if (st == WAIT_DATA && data_in_ready && data_in_valid) begin
        shreg         <= data_in;
        data_in_ready <= 1'b0;
        have_data     <= 1'b1;
      end

      if (st == IDLE) begin
        if (start && !busy) begin
          rw_q    <= rw;
          remain  <= len;
          shreg   <= {slave_addr, rw};
          nack    <= 1'b0;
          busy    <= 1'b1;
          qtr     <= '0;
          bit_cnt <= '0;
          st      <= START;
        end
      end else if (tick) begin
        if (st != WAIT_DATA) qtr <= qtr + 2'd1;
        case (st)
          START: begin
            if (qtr == 2'd0) begin
              sda_out <= 1'b0;
            end else begin
              sclk    <= 1'b0;
              qtr     <= '0;
              bit_cnt <= '0;
              st      <= ADDR;
            end
          end
          ADDR, WR: begin
            case (qtr)
              2'd0: sda_out <= shreg[7];
              2'd1: sclk <= 1'b1;
              2'd2: ;
              default: begin
                sclk    <= 1'b0;
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) st <= (st == ADDR) ? ADDR_ACK : WR_ACK;
              end
            endcase
          end
          ADDR_ACK, WR_ACK: begin
            case (qtr)
              2'd0: sda_out <= 1'b1;
              2'd1: sclk <= 1'b1;
              2'd2: nack <= sda_in;
              default: begin
                sclk <= 1'b0;
                if (nack) begin
                  st <= STOP;
                end else if (st == ADDR_ACK) begin
                  if (remain == '0) begin
                    st <= STOP;
                  end else if (rw_q) begin
                    st <= RD;
                  end else begin
                    st            <= WAIT_DATA;
                    data_in_ready <= 1'b1;
                    have_data     <= 1'b0;
                  end
                end else begin
                  remain <= remain - LEN_W'(1);
                  if (remain == LEN_W'(1)) begin
                    st <= STOP;
                  end else begin
                    st            <= WAIT_DATA;
                    data_in_ready <= 1'b1;
                    have_data     <= 1'b0;
                  end
                end
              end
            endcase
          end
          RD: begin
            case (qtr)
              2'd0: sda_out <= 1'b1;
              2'd1: sclk <= 1'b1;
              2'd2: begin
                shreg <= {shreg[6:0], sda_in};
                if (bit_cnt == 3'd7) begin
                  data_out       <= {shreg[6:0], sda_in};
                  data_out_valid <= 1'b1;
                end
              end
              default: begin
                sclk    <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) st <= RD_ACK;
              end
            endcase
          end
          RD_ACK: begin
            case (qtr)
              2'd0: sda_out <= (remain == LEN_W'(1));
              2'd1: sclk <= 1'b1;
              2'd2: ;
              default: begin
                sclk   <= 1'b0;
                remain <= remain - LEN_W'(1);
                st     <= (remain == LEN_W'(1)) ? STOP : RD;
              end
            endcase
          end
          WAIT_DATA: begin
            if (have_data) begin
              have_data <= 1'b0;
              bit_cnt   <= '0;
              st        <= WR;
            end
          end
          STOP: begin
            case (qtr)
              2'd0: sda_out <= 1'b0;
              2'd1: sclk <= 1'b1;
              default: begin
                sda_out <= 1'b1;
                qtr     <= '0;
                done    <= 1'b1;
                st      <= IDLE;
              end
            endcase
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for i2c_burst_master: behavioural I2C slave on an open-drain SDA,
// scoreboard queues for bytes on the wire, read data and master ACK bits.
module tb_i2c_burst_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned LEN_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             rw = 1'b0;
  logic [6:0]       slave_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       data_in = '0;
  logic             data_in_valid = 1'b0;
  logic             data_in_ready;
  logic [7:0]       data_out;
  logic             data_out_valid;
  logic             busy;
  logic             done;
  logic             nack;
  logic [3:0]       state;
  logic             sclk;
  logic             sda_out;
  logic             sda_in;

  i2c_burst_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .slave_addr(slave_addr),
    .len(len), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_out(data_out),
    .data_out_valid(data_out_valid), .busy(busy), .done(done), .nack(nack),
    .state(state), .sclk(sclk), .sda_out(sda_out), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_sda[$];
  logic [7:0] exp_rd[$];
  logic       exp_mack[$];
  logic [7:0] slv_rd[$];
  logic [7:0] wr_data[16];
  logic [7:0] rd_data[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Open-drain SDA: either side can pull low
  logic slv_sda = 1'b1;
  logic sda_line;
  assign sda_line = sda_out & slv_sda;
  assign sda_in   = sda_line;

  // Behavioural slave
  logic       prev_scl = 1'b1;
  logic       prev_line = 1'b1;
  logic       slv_nack_addr = 1'b0;
  logic       rd_dir = 1'b0;
  logic       mack = 1'b0;
  logic [7:0] rx = '0;
  logic [7:0] txb = '0;
  int         bitcnt = 0;
  int         mode = 0;
  int         n_start = 0;
  int         n_stop = 0;

  always @(negedge clk) begin
    if (!rst) begin
      slv_sda = 1'b1;
      mode    = 0;
      bitcnt  = 0;
    end else if (prev_scl && sclk && prev_line && !sda_line) begin
      mode = 1; bitcnt = 0; mack = 1'b0; n_start++;
    end else if (prev_scl && sclk && !prev_line && sda_line) begin
      mode = 0; n_stop++;
    end else if (!prev_scl && sclk && mode != 0) begin
      if (bitcnt < 8) rx = {rx[6:0], sda_line};
      else if (mode == 3) begin
        mack = sda_line;
        if (exp_mack.size() == 0) check("mack_extra", 32'(1), 32'(0));
        else check("master_ack", 32'(mack), 32'(exp_mack.pop_front()));
      end
      bitcnt++;
    end else if (prev_scl && !sclk && mode != 0) begin
      if (bitcnt == 8) begin
        if (mode != 3) begin
          if (exp_sda.size() == 0) check("sda_extra", 32'(rx), 32'hFFFF);
          else check("sda_byte", 32'(rx), 32'(exp_sda.pop_front()));
          if (mode == 1) begin
            rd_dir  = rx[0];
            slv_sda = slv_nack_addr;
          end else begin
            slv_sda = 1'b0;
          end
        end else begin
          slv_sda = 1'b1;
        end
      end else if (bitcnt == 9) begin
        bitcnt = 0;
        if (mode == 1) mode = (!slv_nack_addr && rd_dir) ? 3 : 2;
        if (mode == 3 && !mack && slv_rd.size() > 0) begin
          txb     = slv_rd.pop_front();
          slv_sda = txb[7];
        end else begin
          slv_sda = 1'b1;
        end
      end else if (mode == 3) begin
        slv_sda = txb[3'(7 - bitcnt)];
      end
    end
    prev_scl  = sclk;
    prev_line = sda_line;
  end

  // Output-side monitors
  int n_done = 0;
  int rdy_cnt = 0;
  int rdy_bad = 0;
  int stall_bad = 0;
  int hs_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (done) n_done++;
      if (data_in_ready) begin
        rdy_cnt++;
        if (state != 4'd9) rdy_bad++;
      end
      if (state == 4'd9 && sclk) stall_bad++;
      if (data_out_valid) begin
        if (exp_rd.size() == 0) check("rd_extra", 32'(data_out), 32'hFFFF);
        else check("data_out", 32'(data_out), 32'(exp_rd.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    if (rst && data_in_valid && data_in_ready) hs_cnt++;
  end

  task automatic xfer(input logic r, input logic [6:0] a, input int n, input int stall,
                      input logic a_nack, input logic done_start);
    int  hs_exp;
    int  guard;
    logic got;
    hs_cnt = 0; rdy_cnt = 0; rdy_bad = 0; stall_bad = 0;
    n_start = 0; n_stop = 0; n_done = 0;
    slv_nack_addr = a_nack;
    exp_sda.push_back({a, r});
    hs_exp = (r || a_nack) ? 0 : n;
    if (r && !a_nack) begin
      for (int i = 0; i < n; i++) begin
        slv_rd.push_back(rd_data[i]);
        exp_rd.push_back(rd_data[i]);
        exp_mack.push_back(i == n - 1);
      end
    end
    @(negedge clk);
    start = 1'b1; rw = r; slave_addr = a; len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < hs_exp; i++) begin
      guard = 0;
      while (!data_in_ready && guard < 3000) begin @(negedge clk); guard++; end
      check("ready_wait", 32'(data_in_ready), 32'(1));
      if (!data_in_ready) break;
      repeat (stall) @(negedge clk);
      data_in = wr_data[i];
      data_in_valid = 1'b1;
      exp_sda.push_back(wr_data[i]);
      guard = 0;
      while (data_in_ready && guard < 10) begin @(negedge clk); guard++; end
      data_in_valid = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", 32'(got), 32'(1));
    check("busy_at_done", 32'(busy), 32'(1));
    if (done_start) begin
      start = 1'b1; rw = 1'b0; slave_addr = 7'h22; len = LEN_W'(1);
      @(negedge clk);
      start = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("nack", 32'(nack), 32'(a_nack));
    check("done_count", 32'(n_done), 32'(1));
    check("start_count", 32'(n_start), 32'(1));
    check("stop_count", 32'(n_stop), 32'(1));
    check("handshakes", 32'(hs_cnt), 32'(hs_exp));
    check("sda_left", 32'(exp_sda.size()), 32'(0));
    check("rd_left", 32'(exp_rd.size()), 32'(0));
    check("mack_left", 32'(exp_mack.size()), 32'(0));
    check("ready_outside_wait", 32'(rdy_bad), 32'(0));
    check("idle_state", 32'(state), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_bus", 32'({sclk, sda_out}), 32'(3));
    if (stall > 0) check("scl_low_in_stall", 32'(stall_bad), 32'(0));
    if (a_nack) check("ready_never", 32'(rdy_cnt), 32'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(state), 32'(0));
    check({tag, "_sclk"}, 32'(sclk), 32'(1));
    check({tag, "_sda"}, 32'(sda_out), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_flags"}, 32'({done, nack, data_in_ready, data_out_valid}), 32'(0));
  endtask

  initial begin
    int   guard;
    int   rises;
    logic ps;

    repeat (3) @(negedge clk);
    check_reset_state("rst");
    check("rst_data_out", 32'(data_out), 32'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Two-byte write
    wr_data[0] = 8'hA5; wr_data[1] = 8'h3C;
    xfer(1'b0, 7'h5A, 2, 0, 1'b0, 1'b0);

    // Two-byte read
    rd_data[0] = 8'h81; rd_data[1] = 8'h7E;
    xfer(1'b1, 7'h5A, 2, 0, 1'b0, 1'b0);

    // Address NACK
    xfer(1'b0, 7'h5A, 2, 0, 1'b1, 1'b0);

    // Address probe, with a start colliding with done
    xfer(1'b0, 7'h5A, 0, 0, 1'b0, 1'b1);

    // Write with data delayed 20 clks
    wr_data[0] = 8'h4E;
    xfer(1'b0, 7'h21, 1, 20, 1'b0, 1'b0);

    // Reset during the third bit of a write byte
    exp_sda.push_back({7'h5A, 1'b0});
    @(negedge clk);
    start = 1'b1; rw = 1'b0; slave_addr = 7'h5A; len = LEN_W'(1);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!data_in_ready && guard < 3000) begin @(negedge clk); guard++; end
    check("rstmid_ready", 32'(data_in_ready), 32'(1));
    data_in = 8'hA5; data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    guard = 0;
    while (state != 4'd4 && guard < 500) begin @(negedge clk); guard++; end
    check("rstmid_in_wr", 32'(state), 32'(4));
    rises = 0; ps = sclk; guard = 0;
    while (rises < 3 && guard < 500) begin
      @(negedge clk);
      if (sclk && !ps) rises++;
      ps = sclk;
      guard++;
    end
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rstmid");
    exp_sda.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Normal transfer after the abort
    wr_data[0] = 8'h96;
    xfer(1'b0, 7'h33, 1, 0, 1'b0, 1'b0);

    // Maximum length write
    for (int i = 0; i < 15; i++) wr_data[i] = 8'($urandom_range(0, 255));
    xfer(1'b0, 7'h10, 15, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_burst_master.md
I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 8, meaning system clocks per SCL quarter-period (legal range 2..1024).
REQ-002 The block SHALL have parameter LEN_W, default 4, meaning the width of the byte-count input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle transfer request.
REQ-006 The block SHALL have port rw, input, 1 bit: 1 selects read, 0 selects write; sampled with start.
REQ-007 The block SHALL have port slave_addr, input, 7 bits: 7-bit target address; sampled with start.
REQ-008 The block SHALL have port len, input, LEN_W bits: data bytes to transfer; sampled with start.
REQ-009 The block SHALL have port data_in, input, 8 bits: write byte.
REQ-010 The block SHALL have port data_in_valid, input, 1 bit: data_in holds a valid byte.
REQ-011 The block SHALL have port data_in_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-012 The block SHALL have port data_out, output, 8 bits: last byte read.
REQ-013 The block SHALL have port data_out_valid, output, 1 bit: one-cycle strobe marking data_out as new.
REQ-014 The block SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle strobe at transfer end.
REQ-016 The block SHALL have port nack, output, 1 bit: the last transfer was aborted by a slave NACK.
REQ-017 The block SHALL have port state, output, 4 bits: current FSM state, for debug.
REQ-018 The block SHALL have port sclk, output, 1 bit: serial clock.
REQ-019 The block SHALL have port sda_out, output, 1 bit: SDA drive, where 1 means released/high.
REQ-020 The block SHALL have port sda_in, input, 1 bit: sampled SDA line.

Function
REQ-021 The tick SHALL be generated when a counter of CLK_DIV clocks wraps; the counter SHALL free-run only while busy, and each SCL bit SHALL span 4 ticks: Q0 SCL low and SDA updated, Q1 SCL rises, Q2 SDA sampled, Q3 SCL falls.
REQ-022 The FSM SHALL have these states and encodings: IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WR=4, WR_ACK=5, RD=6, RD_ACK=7, STOP=8, WAIT_DATA=9.
REQ-023 In IDLE, start SHALL latch rw, slave_addr and len and move the FSM to START; start SHALL be ignored while busy.
REQ-024 START SHALL drive sda_out to 0 while sclk=1 for one tick, then drive sclk to 0 on the next tick, then move to ADDR.
REQ-025 ADDR SHALL shift {slave_addr, rw} MSB first over 8 bits.
REQ-026 ADDR_ACK SHALL release SDA and sample it at Q2: 1 means NACK, setting nack=1 and moving to STOP; 0 means ACK.
REQ-027 On ACK in ADDR_ACK, if len=0 the FSM SHALL move to STOP (address probe); otherwise it SHALL move to WAIT_DATA if rw=0, or to RD if rw=1.
REQ-028 WAIT_DATA SHALL assert data_in_ready and hold sclk low indefinitely; on data_in_valid & data_in_ready it SHALL latch data_in and move to WR on the next tick boundary.
REQ-029 WR SHALL shift the latched byte MSB first, then move to WR_ACK.
REQ-030 WR_ACK on NACK SHALL set nack=1 and move to STOP.
REQ-031 WR_ACK on ACK SHALL decrement the remaining-byte count, moving to STOP if the count reaches 0 and to WAIT_DATA otherwise.
REQ-032 RD SHALL release SDA and sample 8 bits MSB first at Q2; after the 8th sample it SHALL update data_out and pulse data_out_valid for one clk.
REQ-033 RD_ACK SHALL drive SDA=0 (ACK) if bytes remain and SDA=1 (NACK) on the last byte, then move to RD or STOP.
REQ-034 STOP SHALL drive SDA=0 with SCL low, then raise SCL, then raise SDA one tick later, then return to IDLE and pulse done in the same clk.
REQ-035 nack SHALL be cleared on each accepted start and SHALL hold its value after done.
REQ-036 data_in_ready SHALL be 0 in every state except WAIT_DATA.
REQ-037 busy SHALL be 1 from the clk after start is accepted until the clk done pulses, inclusive.
REQ-038 Simultaneous start and done: start SHALL be ignored in that cycle.
REQ-039 len equal to the maximum count (2^LEN_W-1) SHALL transfer exactly that many bytes with no counter wrap.

Reset
REQ-040 On the clk edge where rst=0, the block SHALL force IDLE with sclk=1, sda_out=1, data_out=0, and busy, done, nack, data_in_ready and data_out_valid all 0, and clear all counters.
REQ-041 Reset mid-transfer SHALL abort immediately without generating a STOP, and the bus SHALL be released high.

Verification
REQ-042 Write test: CLK_DIV=4, addr 0x5A, rw=0, len=2, data A5 then 3C, slave ACKs all -> SDA bytes B4, A5, 3C; two data_in_ready handshakes; done=1; nack=0.
REQ-043 Read test: addr 0x5A, rw=1, len=2, slave returns 81 then 7E -> SDA address byte B5; data_out_valid pulses with 81 then 7E; master ACKs after the first byte and NACKs after the second; STOP follows.
REQ-044 Address NACK test: slave leaves SDA high at the address ACK -> nack=1, STOP issued, data_in_ready never asserted, done pulses once.
REQ-045 Probe and stall test: a len=0 write produces START, address, ACK, STOP with no data; a write with data_in_valid delayed 20 clks holds sclk=0 throughout the wait.
REQ-046 Reset mid-byte test: rst=0 during the 3rd bit of WR -> on the next clk state=0, sclk=1, sda_out=1, busy=0; a following start runs a normal transfer.
